// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline controller and a single-port word RAM.
// Byte stores go through a read-modify-write; misaligned word accesses complete without touching memory.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_write,
  input  logic        mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        misalign,
  output logic        ram_en,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);
  localparam logic MEM_OP_WORD = 1'b0;
  localparam logic MEM_OP_BYTE = 1'b1;

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        op_q, op_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        mis_q, mis_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  rd_byte;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte = ram_rdata[7:0];
      2'd1:    rd_byte = ram_rdata[15:8];
      2'd2:    rd_byte = ram_rdata[23:16];
      default: rd_byte = ram_rdata[31:24];
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    op_d    = op_q;
    rbuf_d  = rbuf_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = mem_write;
          op_d    = mem_op;
          if (mem_op == MEM_OP_WORD && addr[1:0] != 2'd0) begin
            state_d = RESP;
            mis_d   = 1'b1;
            done_d  = 1'b1;
          end else if (mem_write && mem_op == MEM_OP_WORD) begin
            state_d = WR;
            wbuf_d  = wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (ram_ready) begin
          rbuf_d = ram_rdata;
          if (we_q) begin
            state_d = MERGE;
          end else begin
            state_d = RESP;
            done_d  = 1'b1;
            rdata_d = (op_q == MEM_OP_BYTE) ? {{24{rd_byte[7]}}, rd_byte} : ram_rdata;
          end
        end
      end
      MERGE: begin
        for (int k = 0; k < 4; k++)
          wbuf_d[8*k +: 8] = (2'(k) == addr_q[1:0]) ? wdata_q[7:0] : rbuf_q[8*k +: 8];
        state_d = WR;
      end
      WR: begin
        if (ram_ready) begin
          state_d = RESP;
          done_d  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // strobes are registered off the next state so they line up with the state they belong to
    busy_d   = (state_d != IDLE);
    ram_en_d = (state_d == RD) || (state_d == WR);
    ram_we_d = (state_d == WR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      op_q     <= 1'b0;
      rbuf_q   <= '0;
      wbuf_q   <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      mis_q    <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      op_q     <= op_d;
      rbuf_q   <= rbuf_d;
      wbuf_q   <= wbuf_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      mis_q    <= mis_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign misalign  = mis_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q[31:2];
  assign ram_wdata = wbuf_q;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 req  input  1  controller memory request; level; sampled only in IDLE.
REQ-005 mem_write  input  1  1 = store, 0 = load.
REQ-006 mem_op  input  1  0 = word (MEM_OP_WORD), 1 = byte (MEM_OP_BYTE).
REQ-007 addr  input  32  byte address from ALU result.
REQ-008 wdata  input  32  store data (rt); byte store uses wdata[7:0].
REQ-009 rdata  output  32  load result; lb result sign-extended.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 misalign  output  1  one-cycle pulse, coincident with done, for a word access with addr[1:0] != 0.
REQ-013 ram_en  output  1  memory access strobe.
REQ-014 ram_we  output  1  memory write enable; valid only with ram_en.
REQ-015 ram_addr  output  30  word address = latched addr[31:2].
REQ-016 ram_wdata  output  32  write word.
REQ-017 ram_rdata  input  32  read word; valid in the cycle ram_ready is high.
REQ-018 ram_ready  input  1  memory completion; ignored while ram_en = 0.

Function
REQ-019 SHALL implement states IDLE, RD, MERGE, WR, RESP.
REQ-020 IDLE with req=1: latch addr, wdata, mem_write, mem_op into internal registers; inputs are not sampled again until the next return to IDLE.
REQ-021 IDLE transitions: misaligned word -> RESP with misalign set and no memory access; word/byte load -> RD; word store -> WR; byte store -> RD (read-modify-write).
REQ-022 RD: ram_en=1, ram_we=0; hold until ram_ready=1, then capture ram_rdata into a read buffer; byte store -> MERGE, otherwise -> RESP.
REQ-023 MERGE: exactly one cycle; ram_en=0; write buffer = read buffer with byte lane k=addr[1:0] replaced by wdata[7:0]; -> WR.
REQ-024 WR: ram_en=1, ram_we=1, ram_wdata = write buffer (word store: latched wdata); hold until ram_ready=1, then -> RESP.
REQ-025 RESP: done=1 for exactly one cycle; -> IDLE.
REQ-026 Byte lanes SHALL be little-endian: lane k = bits [8k+7:8k].
REQ-027 Word load SHALL set rdata = read word; lb SHALL set rdata = sign-extend(lane k); stores and misaligned accesses SHALL leave rdata unchanged.
REQ-028 rdata SHALL update on entry to RESP and hold until the next load reaches RESP.
REQ-029 ram_addr and ram_wdata SHALL stay stable while ram_en=1 and ram_ready=0.
REQ-030 Latency with zero-wait memory (ram_ready high in the first RD/WR cycle), counted from the IDLE cycle where req=1:
  - word load/store: done at +2;
  - byte store: done at +4;
  - misaligned: done at +1.
  - Each cycle ram_ready stays low in RD or WR adds one cycle.
REQ-031 req held high SHALL start a new access in the first IDLE cycle after RESP; back-to-back accesses are legal.
REQ-032 Byte accesses SHALL never flag misalign.

Reset
REQ-033 On reset: state = IDLE; busy, done, misalign, ram_en, ram_we = 0; rdata, ram_wdata, internal buffers = 0; ram_addr = 0.
REQ-034 Reset asserted in any state, including mid-RD/WR with ram_en=1, SHALL take effect at that clock edge and abort the access with no done pulse; reset has priority over req.

Verification
REQ-035 Word load: addr=0x10, memory word 4 = 0x8899AABB, zero-wait -> ram_addr=0x4, done at +2, rdata=0x8899AABB, no write.
REQ-036 lb: addr=0x13, same word -> rdata=0xFFFFFF88; addr=0x10 -> rdata=0xFFFFFFBB; addr=0x11 with word 0x00007F00 -> rdata=0x0000007F.
REQ-037 sb: addr=0x12, wdata=0x123456CC, word 0x8899AABB -> one read then one write of 0x88CCAABB, done at +4, rdata unchanged.
REQ-038 Misaligned: lw addr=0x21 -> misalign and done together at +1, ram_en stays 0.
REQ-039 Wait states: sw addr=0x8, ram_ready low 3 cycles in WR -> ram_addr and ram_wdata stable throughout, done at +5.
REQ-040 Reset during RD of a byte store -> next cycle IDLE, all outputs 0, no write issued, no done pulse.
